// File: rtl/onn_pkg.sv
// Shared ONN array defaults and the phase-vector packing helper used by the
// phase register bank and the oscillator array.
package onn_pkg;

  localparam int unsigned N_CH_DEF        = 15;
  localparam int unsigned PW_DEF          = 4;
  localparam int unsigned RESET_PHASE_DEF = 8;

  // LSB of channel ch inside a packed phase vector of pw-bit fields.
  function automatic int unsigned phase_lsb(input int unsigned ch, input int unsigned pw);
    return ch * pw;
  endfunction

endpackage

// File: rtl/onn_popcount.sv
// Combinational ones counter over an N-bit vector.
module onn_popcount #(
  parameter int unsigned N = 15
) (
  input  logic [N-1:0]             bits,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(N + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/phase_reg_bank.sv
// Per-neuron phase registers with change detection, change count and
// consecutive-stable-check convergence tracking.
module phase_reg_bank
  import onn_pkg::*;
#(
  parameter int unsigned N_CH        = N_CH_DEF,
  parameter int unsigned PW          = PW_DEF,
  parameter int unsigned RESET_PHASE = RESET_PHASE_DEF,
  parameter int unsigned STABLE_N    = 3,
  parameter int unsigned ITER_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            drop,
  input  logic [N_CH*PW-1:0]              ini_phase,
  input  logic                            check,
  input  logic [N_CH*PW-1:0]              phase,
  output logic [N_CH*PW-1:0]              phi_out,
  output logic [N_CH-1:0]                 changed,
  output logic [$clog2(N_CH+1)-1:0]       n_changed,
  output logic                            any_changed,
  output logic [$clog2(STABLE_N+1)-1:0]   stable_cnt,
  output logic                            converged,
  output logic [ITER_W-1:0]               iter_cnt,
  output logic                            check_done
);

  localparam int unsigned CW = $clog2(N_CH + 1);
  localparam int unsigned SW = $clog2(STABLE_N + 1);
  localparam logic [SW-1:0] StableMax = SW'(STABLE_N);

  logic [N_CH-1:0] flags_new;
  logic [CW-1:0]   cnt_new;
  logic [SW-1:0]   stable_nxt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam int unsigned Lsb = phase_lsb(i, PW);
    logic [PW-1:0] ph_q;
    logic          chg_q;

    // Compare against the pre-edge register value.
    assign flags_new[i] = (ph_q != phase[Lsb +: PW]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ph_q  <= PW'(RESET_PHASE);
        chg_q <= 1'b0;
      end else if (drop) begin
        ph_q  <= ini_phase[Lsb +: PW];
        chg_q <= 1'b0;
      end else if (check) begin
        ph_q  <= phase[Lsb +: PW];
        chg_q <= flags_new[i];
      end
    end

    assign phi_out[Lsb +: PW] = ph_q;
    assign changed[i]         = chg_q;
  end

  onn_popcount #(
    .N (N_CH)
  ) u_popcount (
    .bits  (flags_new),
    .count (cnt_new)
  );

  always_comb begin
    stable_nxt = stable_cnt;
    if (|flags_new) begin
      stable_nxt = '0;
    end else if (stable_cnt != StableMax) begin
      stable_nxt = stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_changed   <= '0;
      any_changed <= 1'b0;
      stable_cnt  <= '0;
      converged   <= 1'b0;
      iter_cnt    <= '0;
      check_done  <= 1'b0;
    end else if (drop) begin
      n_changed   <= '0;
      any_changed <= 1'b0;
      stable_cnt  <= '0;
      converged   <= 1'b0;
      iter_cnt    <= '0;
      check_done  <= 1'b0;
    end else if (check) begin
      n_changed   <= cnt_new;
      any_changed <= |flags_new;
      stable_cnt  <= stable_nxt;
      converged   <= (stable_nxt == StableMax);
      if (!(&iter_cnt)) begin
        iter_cnt <= iter_cnt + 1'b1;
      end
      check_done  <= 1'b1;
    end else begin
      check_done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phase_reg_bank.sv
// Directed self-checking bench for phase_reg_bank (default build plus a
// 2-bit iteration counter build for saturation).
module tb_phase_reg_bank;

  localparam int NCH = 15;
  localparam int PW  = 4;
  localparam int VW  = NCH * PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          drop;
  logic          check;
  logic [VW-1:0] ini_phase;
  logic [VW-1:0] phase;

  logic [VW-1:0]  phi_out;
  logic [NCH-1:0] changed;
  logic [3:0]     n_changed;
  logic           any_changed;
  logic [1:0]     stable_cnt;
  logic           converged;
  logic [7:0]     iter_cnt;
  logic           check_done;

  logic [VW-1:0]  phi_out2;
  logic [NCH-1:0] changed2;
  logic [3:0]     n_changed2;
  logic           any_changed2;
  logic [1:0]     stable_cnt2;
  logic           converged2;
  logic [1:0]     iter_cnt2;
  logic           check_done2;

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] pat_a;
  logic [VW-1:0] pat_b;
  logic [VW-1:0] rst_pat;

  always #5 clk = ~clk;

  phase_reg_bank u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .drop        (drop),
    .ini_phase   (ini_phase),
    .check       (check),
    .phase       (phase),
    .phi_out     (phi_out),
    .changed     (changed),
    .n_changed   (n_changed),
    .any_changed (any_changed),
    .stable_cnt  (stable_cnt),
    .converged   (converged),
    .iter_cnt    (iter_cnt),
    .check_done  (check_done)
  );

  phase_reg_bank #(
    .ITER_W (2)
  ) u_dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .drop        (drop),
    .ini_phase   (ini_phase),
    .check       (check),
    .phase       (phase),
    .phi_out     (phi_out2),
    .changed     (changed2),
    .n_changed   (n_changed2),
    .any_changed (any_changed2),
    .stable_cnt  (stable_cnt2),
    .converged   (converged2),
    .iter_cnt    (iter_cnt2),
    .check_done  (check_done2)
  );

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drop = 0; check = 0; ini_phase = '0; phase = '0; rst_n = 1;
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    checks++;
    if (phi_out !== rst_pat) begin
      errors++; $display("FAIL reset_phi: got %h want %h", phi_out, rst_pat);
    end
    checks++;
    if ({changed, n_changed, any_changed, stable_cnt, converged, iter_cnt, check_done} !== '0) begin
      errors++;
      $display("FAIL reset_flags: got chg=%h n=%0d any=%b st=%0d cv=%b it=%0d cd=%b want all 0",
               changed, n_changed, any_changed, stable_cnt, converged, iter_cnt, check_done);
    end
    tick();
    rst_n = 1;
    tick();
    checks++;
    if (phi_out !== rst_pat || iter_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_release_hold: got phi=%h it=%0d want %h 0", phi_out, iter_cnt, rst_pat);
    end
  endtask

  task automatic test_drop();
    ini_phase = pat_a;
    drop = 1;
    tick();
    drop = 0;
    checks++;
    if (phi_out !== pat_a) begin
      errors++; $display("FAIL drop_phi: got %h want %h", phi_out, pat_a);
    end
    checks++;
    if (iter_cnt !== 8'd0 || changed !== '0 || check_done !== 1'b0) begin
      errors++;
      $display("FAIL drop_flags: got it=%0d chg=%h cd=%b want 0 0 0", iter_cnt, changed, check_done);
    end
  endtask

  task automatic test_partial_change();
    logic [VW-1:0] p;
    p = pat_a;
    p[2*PW +: PW] = 4'd5;
    p[7*PW +: PW] = 4'd0;
    phase = p;
    check = 1;
    tick();
    check = 0;
    checks++;
    if (changed !== 15'h0084 || n_changed !== 4'd2 || any_changed !== 1'b1) begin
      errors++;
      $display("FAIL partial_flags: got chg=%h n=%0d any=%b want 0084 2 1", changed, n_changed, any_changed);
    end
    checks++;
    if (stable_cnt !== 2'd0 || iter_cnt !== 8'd1 || check_done !== 1'b1 || phi_out !== p) begin
      errors++;
      $display("FAIL partial_state: got st=%0d it=%0d cd=%b phi=%h want 0 1 1 %h",
               stable_cnt, iter_cnt, check_done, phi_out, p);
    end
    tick();
    checks++;
    if (check_done !== 1'b0 || changed !== 15'h0084 || iter_cnt !== 8'd1) begin
      errors++;
      $display("FAIL idle_hold: got cd=%b chg=%h it=%0d want 0 0084 1", check_done, changed, iter_cnt);
    end
  endtask

  task automatic test_convergence();
    logic [1:0] exp_st [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic       exp_cv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [VW-1:0] p;
    check = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (stable_cnt !== exp_st[k] || converged !== exp_cv[k] || changed !== '0 ||
          check_done !== 1'b1 || iter_cnt !== 8'(k + 2)) begin
        errors++;
        $display("FAIL conv_step%0d: got st=%0d cv=%b chg=%h cd=%b it=%0d want %0d %b 0 1 %0d",
                 k, stable_cnt, converged, changed, check_done, iter_cnt, exp_st[k], exp_cv[k], k + 2);
      end
    end
    // Single-channel change must drop convergence on the same edge.
    p = phase;
    p[14*PW +: PW] = p[14*PW +: PW] + 4'd1;
    phase = p;
    tick();
    check = 0;
    checks++;
    if (converged !== 1'b0 || stable_cnt !== 2'd0 || changed !== 15'h4000 ||
        n_changed !== 4'd1 || any_changed !== 1'b1) begin
      errors++;
      $display("FAIL conv_break: got cv=%b st=%0d chg=%h n=%0d any=%b want 0 0 4000 1 1",
               converged, stable_cnt, changed, n_changed, any_changed);
    end
  endtask

  task automatic test_collision();
    check = 1;
    tick();
    checks++;
    if (stable_cnt !== 2'd1) begin
      errors++; $display("FAIL coll_pre: got st=%0d want 1", stable_cnt);
    end
    ini_phase = pat_b;
    phase     = pat_a;
    drop      = 1;
    check     = 1;
    tick();
    drop  = 0;
    check = 0;
    checks++;
    if (phi_out !== pat_b || iter_cnt !== 8'd0 || check_done !== 1'b0 ||
        changed !== '0 || stable_cnt !== 2'd0) begin
      errors++;
      $display("FAIL collision: got phi=%h it=%0d cd=%b chg=%h st=%0d want %h 0 0 0 0",
               phi_out, iter_cnt, check_done, changed, stable_cnt, pat_b);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_it [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    ini_phase = pat_a;
    phase     = pat_a;
    drop = 1;
    tick();
    drop  = 0;
    check = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (iter_cnt2 !== exp_it[k] || iter_cnt !== 8'(k + 1)) begin
        errors++;
        $display("FAIL sat_step%0d: got it2=%0d it=%0d want %0d %0d",
                 k, iter_cnt2, iter_cnt, exp_it[k], k + 1);
      end
    end
  endtask

  task automatic test_reset_midrun();
    // check still high; reset must win immediately.
    #2 rst_n = 0;
    #1;
    checks++;
    if (phi_out !== rst_pat || converged !== 1'b0 || stable_cnt !== 2'd0 ||
        iter_cnt !== 8'd0 || iter_cnt2 !== 2'd0 || check_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: got phi=%h cv=%b st=%0d it=%0d it2=%0d cd=%b want %h 0 0 0 0 0",
               phi_out, converged, stable_cnt, iter_cnt, iter_cnt2, check_done, rst_pat);
    end
    check = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      pat_a[i*PW +: PW]   = 4'(i);
      pat_b[i*PW +: PW]   = 4'(15 - i);
      rst_pat[i*PW +: PW] = 4'd8;
    end
    test_reset();
    test_drop();
    test_partial_change();
    test_convergence();
    test_collision();
    test_saturation();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_reg_bank.md
Name: phase_reg_bank

Overview:
Parametrised bank of oscillator phase registers for the ONN array: one register per neuron, all in one clock domain. Loads an initial phase pattern on drop, and captures the network's updated phases on each check strobe. Flags per-channel changes, counts them, and declares convergence after a programmable number of consecutive unchanged checks. Sits between the oscillator/phase-detector array and the readout/control FSM.

Parameters:
N_CH, 15, number of neurons/channels (3x5 array)
PW, 4, phase width in bits
RESET_PHASE, 8, phase loaded into every channel on reset
STABLE_N, 3, consecutive no-change checks required to assert converged (>=1)
ITER_W, 8, width of check-iteration counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
drop  in  1  load ini_phase into all channels (sampled on clk rising edge)
ini_phase  in  N_CH*PW  initial phase pattern, channel i at [i*PW +: PW]
check  in  1  capture phase into all channels and compare (sampled on clk)
phase  in  N_CH*PW  current network phases, same packing
phi_out  out  N_CH*PW  registered phase per channel
changed  out  N_CH  per-channel "phase differed at last check" flag
n_changed  out  $clog2(N_CH+1)  popcount of changed
any_changed  out  1  OR of changed
stable_cnt  out  $clog2(STABLE_N+1)  consecutive no-change checks, saturating
converged  out  1  stable_cnt == STABLE_N
iter_cnt  out  ITER_W  checks since last drop, saturating at all-ones
check_done  out  1  one-cycle pulse the cycle after a check is applied

Behaviour:
- Reset (rst_n low, async): every phi_out channel = RESET_PHASE; changed=0, n_changed=0, any_changed=0, stable_cnt=0, converged=0, iter_cnt=0, check_done=0. Release takes effect at the next clk edge.
- All state is updated on the clk rising edge; no combinational path from inputs to outputs.
- Drop (drop=1): phi_out <= ini_phase; changed, n_changed, any_changed, stable_cnt, converged and iter_cnt are cleared; check_done=0.
- Drop and check in the same cycle: drop wins and check is ignored.
- Check (check=1, drop=0): for each channel i, changed[i] <= (phi_out[i] != phase[i]) and phi_out[i] <= phase[i]. The compare uses pre-edge phi_out. In the same edge:
  - n_changed <= popcount of the new flags; any_changed <= |new flags.
  - If the new flags are all zero, stable_cnt increments, saturating at STABLE_N; otherwise it clears to 0.
  - converged <= (next stable_cnt == STABLE_N).
  - iter_cnt increments, saturating at 2^ITER_W-1.
  - check_done pulses high for exactly the following cycle.
- Latency: all outputs reflect a check or drop one clk edge later.
- Check held high for multiple cycles means one check per cycle. The second consecutive check normally sees no change unless phase moves.
- Idle (drop=0, check=0): all registers hold; check_done=0.
- After converged=1, further no-change checks keep converged=1. Any single-channel change clears converged and stable_cnt on that edge.
- Reset mid-run: everything returns to reset values immediately, regardless of drop/check.
- Phase values are unsigned PW-bit. The compare is exact equality with no wrap tolerance.

Decomposition:
- Shared package onn_pkg holds the N_CH, PW and RESET_PHASE defaults, plus a phase-vector packing helper (slice index function) shared with the oscillator array.
- One natural sub-module: onn_popcount (parametrised N-input ones counter, combinational). It feeds the n_changed register.
- The per-channel register and compare is a generate loop, not a separate module.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> phi_out all channels = 8 immediately; all flags and counters 0.
- Drop: ini_phase channels = 0..14 mod 16, drop=1 for one cycle -> next edge phi_out = ini_phase, iter_cnt=0, changed=0.
- Partial change: after drop, check=1 with channels 2 and 7 differing -> changed=0x0084, n_changed=2, any_changed=1, stable_cnt=0, iter_cnt=1, check_done pulse one cycle later.
- Convergence: hold phase constant and issue check 3 times after a change -> stable_cnt 1,2,3. converged=1 after the third. A fourth check keeps converged=1 and stable_cnt=3.
- Drop/check collision: drop=1 and check=1 same cycle -> phi_out = ini_phase, iter_cnt=0, no check_done.
- Saturation: ITER_W=2, 5 checks with no drop -> iter_cnt reads 1,2,3,3,3.
